// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic matrix-multiply array and its result
// drain controller.
//   DIM_DEFAULT / BITS_C_DEFAULT : default array dimension and accumulator
//                                  width, shared with the array itself.
//   c_row_t                      : one C row, DIM signed accumulators.
//   drain_state_t                : drain controller FSM states.
// ----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DIM_DEFAULT    = 8;
  localparam int BITS_C_DEFAULT = 16;

  typedef logic signed [DIM_DEFAULT-1:0][BITS_C_DEFAULT-1:0] c_row_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    OUT  = 3'd2,
    CLR  = 3'd3,
    DONE = 3'd4
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// ----------------------------------------------------------------------------
// systolic_result_drain
// Read-side controller for the systolic array. After a compute pass it walks
// the C-row select from 0 to DIM-1, registers each selected accumulator row
// and presents it as one beat on a valid/ready stream.
//
// Build option: CLEAR_ON_READ_EN -- when defined, each row is zeroed through
// the array's row-write port in the cycle after its beat is accepted. When
// undefined, WrEn and Cin are tied to 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse that begins a drain (ignored when busy)
//   busy            high from the cycle after start through the done cycle
//   done            one-cycle pulse once the last row has been handled
//   Crow            registered row select to the array
//   Cout            selected-row accumulators (combinational in Crow)
//   WrEn, Cin       row write port to the array (clear-on-read)
//   out_valid/out_ready/out_data/out_row/out_last   result stream
//   dbg_state       current FSM state, for observation only
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and the beat has not transferred,
// out_data, out_row and out_last hold stable; out_valid does not depend on
// out_ready, and out_ready may be high before out_valid rises.
// ----------------------------------------------------------------------------
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEFAULT,
  parameter int DIM    = DIM_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DIM)-1:0]     Crow,
  input  logic [DIM*BITS_C-1:0]      Cout,
  output logic                       WrEn,
  output logic [DIM*BITS_C-1:0]      Cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM*BITS_C-1:0]      out_data,
  output logic [$clog2(DIM)-1:0]     out_row,
  output logic                       out_last,
  output logic [2:0]                 dbg_state
);

  localparam int RW = $clog2(DIM);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);

  drain_state_t           state_q, state_d;
  logic [RW-1:0]          row_cnt_q, row_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DIM*BITS_C-1:0]  out_data_q, out_data_d;
  logic [RW-1:0]          out_row_q, out_row_d;
  logic                   out_last_q, out_last_d;
  logic                   advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          row_cnt_d = '0;
          state_d   = SEL;
        end
      end
      SEL: begin
        // Crow has been stable on row_cnt for this whole cycle, so Cout is
        // the settled row.
        out_data_d  = Cout;
        out_row_d   = row_cnt_q;
        out_last_d  = (row_cnt_q == LAST_ROW);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef CLEAR_ON_READ_EN
          state_d = CLR;
`else
          advance = 1'b1;
`endif
        end
      end
      CLR: begin
        advance = 1'b1;
      end
      DONE: begin
        // Leave the row select at 0 for the next pass.
        row_cnt_d = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared "next row or finish" decision after a row is fully handled.
    if (advance) begin
      if (row_cnt_q == LAST_ROW) begin
        state_d = DONE;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
        state_d   = SEL;
      end
    end
  end

  // The row counter doubles as the registered row select: it only moves on
  // the transition into SEL (and back to 0 after DONE).
  assign Crow      = row_cnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;
  assign Cin       = '0;

`ifdef CLEAR_ON_READ_EN
  assign WrEn = (state_q == CLR);
`else
  assign WrEn = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
`timescale 1ns/1ps
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int DIM    = DIM_DEFAULT;
  localparam int BITS_C = BITS_C_DEFAULT;
  localparam int RW     = $clog2(DIM);
  localparam int DW     = DIM * BITS_C;
  localparam int EW     = DW + RW + 1;
`ifdef CLEAR_ON_READ_EN
  localparam int ROW_CYC = 3;
`else
  localparam int ROW_CYC = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           start, busy, done, WrEn, out_valid, out_ready, out_last;
  logic [RW-1:0]  Crow, out_row;
  logic [DW-1:0]  Cout, Cin, out_data;
  logic [2:0]     dbg_state;

  systolic_result_drain #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .Crow(Crow), .Cout(Cout), .WrEn(WrEn), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [EW-1:0] got,
                          input logic [EW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- array model ----------------
  logic [DW-1:0] arr      [DIM];
  logic [DW-1:0] load_img [DIM];
  logic          load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < DIM; r++) arr[r] <= load_img[r];
    end else if (WrEn) begin
      arr[Crow] <= Cin;
    end
  end
  assign Cout = arr[Crow];

  // ---------------- ready driver ----------------
  // modes: 0 always ready, 1 random, 2 random + 5-cycle stall at beat 3,
  //        3 ready only for the first 4 beats
  int ready_mode = 0;
  int drain_id   = 0;
  int beat_base  = 0;
  int beats_total = 0;
  int stall_cnt  = 0;
  bit stall_done = 0;
  int seen_id    = 0;

  always @(posedge clk) begin
    #1;
    if (seen_id != drain_id) begin
      seen_id    = drain_id;
      stall_done = 0;
      stall_cnt  = 0;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (ready_mode == 2 && (beats_total - beat_base) == 3 && !stall_done) begin
      out_ready  = 1'b0;
      stall_cnt  = 4;
      stall_done = 1;
    end else begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        3:       out_ready = ((beats_total - beat_base) < 4);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor (negedge sampling) ----------------
  int done_total = 0;
  int busy_total = 0;
  int wren_total = 0;
  logic [RW-1:0] last_hs_row = '0;
  logic [EW-1:0] e;
  bit            stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic [RW-1:0] prev_row, prev_crow;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got row %0d expected no beat", out_row);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_data", out_data, e[DW-1:0]);
          check_eq("beat_row", out_row, e[DW+RW-1:DW]);
          check_eq("beat_last", out_last, e[EW-1]);
        end
        beats_total++;
        last_hs_row = out_row;
      end
      if (stall_prev) begin
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_row", out_row, prev_row);
        check_eq("stall_crow", Crow, prev_crow);
      end
      if (out_valid) check_eq("crow_hold", Crow, out_row);
      if (done) done_total++;
      if (busy) busy_total++;
      if (WrEn) begin
        wren_total++;
        check_eq("clr_row", Crow, last_hs_row);
        check_eq("clr_data", Cin, '0);
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    prev_row   = out_row;
    prev_crow  = Crow;
  end

  // ---------------- driver tasks ----------------
  task automatic push_rows_from_img();
    for (int r = 0; r < DIM; r++)
      exp_q.push_back({(r == DIM - 1), RW'(r), load_img[r]});
  endtask

  // kind 0: 100*r+c, 1: random, 2: random with row 2 = -32768, row 5 = -1
  task automatic preload(input int kind);
    logic [BITS_C-1:0] v;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (kind)
          0:       v = BITS_C'(100 * r + c);
          1:       v = BITS_C'($urandom);
          default: v = (r == 2) ? 16'h8000 : (r == 5) ? 16'hFFFF : BITS_C'($urandom);
        endcase
        load_img[r][c*BITS_C +: BITS_C] = v;
      end
    end
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic run_drain(input int mode, input bit ign, input bit chk_cyc,
                           input string tag);
    int b0, d0, y0, w0, cyc;
    bit seen, p1, p4, pd;
    b0 = beats_total; d0 = done_total; y0 = busy_total; w0 = wren_total;
    beat_base  = b0;
    ready_mode = mode;
    drain_id++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0; cyc = 0; p1 = 0; p4 = 0; pd = 0;
    while (!seen && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) seen = 1;
      if (ign) begin
        if (done && !pd) begin
          start = 1'b1; pd = 1;
        end else if ((beats_total - b0) == 1 && !p1) begin
          start = 1'b1; p1 = 1;
        end else if ((beats_total - b0) == 4 && !p4) begin
          start = 1'b1; p4 = 1;
        end
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", tag);
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_beats"}, beats_total - b0, DIM);
    check_eq({tag, "_done"}, done_total - d0, 1);
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
    check_eq({tag, "_crow0"}, Crow, '0);
    if (chk_cyc) check_eq({tag, "_busy_cyc"}, busy_total - y0, ROW_CYC * DIM + 1);
`ifdef CLEAR_ON_READ_EN
    check_eq({tag, "_wren"}, wren_total - w0, DIM);
`else
    check_eq({tag, "_wren"}, wren_total - w0, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_crow"}, Crow, '0);
    check_eq({tag, "_wren"}, WrEn, 1'b0);
    check_eq({tag, "_cin"}, Cin, '0);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_data"}, out_data, '0);
    check_eq({tag, "_row"}, out_row, '0);
    check_eq({tag, "_last"}, out_last, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, cyc;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; load_req = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // 1. basic drain, ready high
    preload(0);
    push_rows_from_img();
    run_drain(0, 0, 1, "basic");

`ifdef CLEAR_ON_READ_EN
    // 6. array cleared by the previous drain; second drain returns zeros
    for (int r = 0; r < DIM; r++) check_eq("arr_zero", arr[r], '0);
    for (int r = 0; r < DIM; r++) exp_q.push_back({(r == DIM - 1), RW'(r), DW'(0)});
    run_drain(0, 0, 1, "zero_drain");
`endif

    // 2. backpressure: random ready plus a 5-cycle stall at beat 3
    preload(1);
    push_rows_from_img();
    run_drain(2, 0, 0, "bp");

    // 3. negative values, random ready
    preload(2);
    push_rows_from_img();
    run_drain(1, 0, 0, "neg");

    // 4. ignored start pulses at beats 1, 4 and in the done cycle
    preload(1);
    push_rows_from_img();
    run_drain(0, 1, 1, "ign");

    // 5. reset while row 4 is waiting on the stream
    preload(0);
    push_rows_from_img();
    w0 = wren_total;
    beat_base  = beats_total;
    ready_mode = 3;
    drain_id++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_row == RW'(4)) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rst_reached_row4", out_valid && out_row == RW'(4), 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
`ifdef CLEAR_ON_READ_EN
    check_eq("midrst_wren", wren_total - w0, 4);
`else
    check_eq("midrst_wren", wren_total - w0, 0);
`endif
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_busy", busy, 1'b0);
    preload(1);
    push_rows_from_img();
    run_drain(0, 0, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
